// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for a bank of common-anode 7-segment
// digits. A single external hex-to-7-segment decoder is shared between all
// digits: the controller presents one nibble at a time on dec_in_o, the
// decoder answers combinationally on dec_out_i in the same cycle, and the
// pattern is registered onto seg_o while one active-low anode is driven.
//
// Every digit slot is REFRESH_DIV cycles long. The first cycle of a slot
// (BLANK) turns all anodes off so the previous digit's segments never ghost
// onto the next anode. The remaining cycles (SHOW) light the selected digit.
//
// New display values arrive over a valid/ready handshake. An accepted value
// waits in a one-entry pending register and is copied into the active
// register only at the end of a frame, so a frame never mixes two values.
//
// Parameters
//   NUM_DIGITS    number of scanned digits (>= 2)
//   REFRESH_DIV   clock cycles per digit slot (>= 2)
//   BLANK_LEADING 1 = blank leading zero digits (digit 0 always shown)
//
// Ports
//   clk_i       system clock
//   rst_i       synchronous reset, active-high
//   en_i        1 = display on, 0 = all anodes off and segments dark
//   in_valid_i  new display value offered
//   in_ready_o  controller can accept a value this cycle
//   in_value_i  nibble i drives digit i (digit 0 least significant)
//   dec_in_o    nibble presented to the shared decoder
//   dec_out_i   active-low pattern returned by the decoder, same cycle
//   seg_o       registered active-low segments {g,f,e,d,c,b,a}
//   an_o        registered active-low one-hot anode select
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [4*NUM_DIGITS-1:0] in_value_i,
  output logic [3:0]              dec_in_o,
  input  logic [6:0]              dec_out_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_DARK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = '1;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         active_q;
  logic [VW-1:0]         pending_q;
  logic                  pending_full_q;
  logic                  in_ready_q;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  logic                  last_cnt;
  logic                  last_idx;
  logic                  frame_end;
  logic                  transfer;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  zero_above;
  logic                  digit_blank;
  logic [6:0]            seg_show;
  logic [NUM_DIGITS-1:0] an_show;

  assign in_ready_o = in_ready_q;
  assign seg_o      = seg_q;
  assign an_o       = an_q;

  // The decoder input follows the active register and digit index directly.
  // idx only moves when a new slot begins and active only changes at a frame
  // boundary (which is also a slot start), so dec_in_o is stable for a whole
  // slot and the pattern coming back is ready before the BLANK cycle ends.
  assign dec_in_o = active_q[{idx_q, 2'b00} +: 4];

  // Leading-zero mask: walk from the most significant digit downwards and
  // keep track of whether every nibble seen so far is zero. Digit 0 is
  // never blanked so a value of zero still shows a single '0'.
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (active_q[4*i +: 4] == 4'h0);
      if (BLANK_LEADING && (i != 0)) begin
        blank_mask[i] = zero_above;
      end
    end
  end

  assign digit_blank = blank_mask[idx_q];
  assign seg_show    = digit_blank ? SEG_DARK : dec_out_i;
  assign an_show     = ~(NUM_DIGITS'(1) << idx_q);

  // Slot and digit sequencing. The slot counter runs 0..REFRESH_DIV-1 and
  // cnt==0 is the BLANK cycle; the digit index advances when the slot wraps.
  always_comb begin
    last_cnt  = (cnt_q == CNT_MAX);
    last_idx  = (idx_q == IDX_MAX);
    frame_end = (state_q == SHOW) && last_cnt && last_idx;
    transfer  = in_valid_i && in_ready_q;

    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    state_d = SHOW;
    if (last_cnt) begin
      cnt_d   = '0;
      state_d = BLANK;
      idx_d   = last_idx ? '0 : (idx_q + IW'(1));
    end
  end

  // Main controller register block.
  //
  // Outputs are registered for the state being entered so that an_o is all
  // ones during exactly the BLANK cycle of each slot. The segment register
  // is reloaded on every cycle that enters or stays in SHOW: since the
  // decoder input does not move within a slot this is the same as holding
  // the value, and it lets the display pick up mid-slot when en_i returns.
  //
  // The handshake keeps running while the display is disabled. The pending
  // value is promoted at the frame boundary; a new value can only be
  // accepted while nothing is pending, so promotion and capture never
  // collide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= BLANK;
      cnt_q          <= '0;
      idx_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      in_ready_q     <= 1'b1;
      seg_q          <= SEG_DARK;
      an_q           <= AN_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;

      if (frame_end && pending_full_q) begin
        active_q       <= pending_q;
        pending_full_q <= 1'b0;
        in_ready_q     <= 1'b1;
      end else if (transfer) begin
        pending_q      <= in_value_i;
        pending_full_q <= 1'b1;
        in_ready_q     <= 1'b0;
      end

      if (!en_i) begin
        an_q  <= AN_OFF;
        seg_q <= SEG_DARK;
      end else if (state_d == BLANK) begin
        an_q  <= AN_OFF;
      end else begin
        an_q  <= an_show;
        seg_q <= seg_show;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Self-checking bench for seg7_scan_ctrl with 4 digits and a 4-cycle slot
// (16-cycle frame). The bench plays the external hex decoder itself and
// keeps a reference model that reasons purely in terms of elapsed cycles
// since reset: slot phase, digit number and frame boundaries are derived
// with division and modulo, and the displayed value follows the
// pending/active rules of the handshake.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

   localparam int N     = 4;
   localparam int DIV   = 4;
   localparam int FRAME = N * DIV;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          inValid;
   logic          inReady;
   logic [15:0]   inValue;
   logic [3:0]    decIn;
   logic [6:0]    decOut;
   logic [6:0]    seg;
   logic [3:0]    an;

   int            checkCount = 0;
   int            passCount  = 0;

   // Reference model state
   int            mT;
   logic [15:0]   mActive;
   logic [15:0]   mPending;
   bit            mPendingFull;
   bit            mInReset;
   bit            mEnPrev;

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Active-low hex decoder, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] decodeHex(input logic [3:0] nib);
      case (nib)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   // The shared decoder sits outside the controller and answers combinationally
   assign decOut = decodeHex(decIn);

   seg7_scan_ctrl #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (DIV),
      .BLANK_LEADING(1'b1)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (en),
      .in_valid_i (inValid),
      .in_ready_o (inReady),
      .in_value_i (inValue),
      .dec_in_o   (decIn),
      .dec_out_i  (decOut),
      .seg_o      (seg),
      .an_o       (an)
   );

   // Nibble of a display value belonging to a given digit
   function automatic logic [3:0] nibbleOf(input logic [15:0] value, input int digit);
      logic [15:0] shifted;
      shifted = value >> (4 * digit);
      return shifted[3:0];
   endfunction

   // Pattern the digit should show: dark when it is a leading zero
   function automatic logic [6:0] expectedSeg(input logic [15:0] value, input int digit);
      if (digit > 0 && (value >> (4 * digit)) == 16'h0)
         return 7'h7F;
      return decodeHex(nibbleOf(value, digit));
   endfunction

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s at cycle %0d (time %0t): got %h, expected %h",
                  tag, mT, $time, got, exp);
      end
   endtask

   // Advance the model across one clock edge using the inputs held there
   task automatic modelStep();
      if (rst) begin
         mT           = 0;
         mActive      = '0;
         mPending     = '0;
         mPendingFull = 1'b0;
         mInReset     = 1'b1;
         mEnPrev      = 1'b1;
      end else begin
         if ((mT % FRAME) == FRAME - 1 && mPendingFull) begin
            mActive      = mPending;
            mPendingFull = 1'b0;
         end else if (inValid && !mPendingFull) begin
            mPending     = inValue;
            mPendingFull = 1'b1;
         end
         mT++;
         mInReset = 1'b0;
         mEnPrev  = en;
      end
   endtask

   // Compare every DUT output with what the model says for this cycle
   task automatic checkCycle();
      int          phase;
      int          digit;
      logic [3:0]  expAn;
      logic [3:0]  expDec;
      logic [6:0]  expSeg;
      logic        expReady;
      phase    = mT % DIV;
      digit    = (mT / DIV) % N;
      expReady = !mPendingFull;
      expDec   = nibbleOf(mActive, digit);
      checkOutput("in_ready", {15'h0, inReady}, {15'h0, expReady});
      checkOutput("dec_in", {12'h0, decIn}, {12'h0, expDec});
      if (mInReset || !mEnPrev) begin
         checkOutput("an_dark", {12'h0, an}, 16'h000F);
         checkOutput("seg_dark", {9'h0, seg}, 16'h007F);
      end else if (phase == 0) begin
         checkOutput("an_blank", {12'h0, an}, 16'h000F);
      end else begin
         expAn  = ~(4'b0001 << digit);
         expSeg = expectedSeg(mActive, digit);
         checkOutput("an_show", {12'h0, an}, {12'h0, expAn});
         checkOutput("seg_show", {9'h0, seg}, {9'h0, expSeg});
      end
   endtask

   // Hold one set of inputs for n cycles, checking after every edge
   task automatic applyStimulus(input bit r, input bit e, input bit v,
                                input logic [15:0] val, input int n);
      for (int i = 0; i < n; i++) begin
         rst     = r;
         en      = e;
         inValid = v;
         inValue = val;
         @(posedge clk);
         modelStep();
         @(negedge clk);
         checkCycle();
      end
   endtask

   // Directed scenarios followed by a randomized soak
   initial begin
      logic [15:0] randVal;
      logic [15:0] mask;
      bit          rR;
      bit          rE;
      bit          rV;

      $display("[TB] seg7_scan_ctrl bench starting");

      // Reset held for two cycles, then the first BLANK slot
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 5);

      // Value accepted mid-frame, shown from the next frame onwards
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 40);

      // Steady value to watch scan order and wrap-around
      applyStimulus(1'b0, 1'b1, 1'b1, 16'hABCD, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 48);

      // Leading zero suppression
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0050, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 36);
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 36);

      // Back-pressure: second value must wait for the first to land
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h1111, 5);
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h2222, 40);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 36);

      // Display disabled for 10 cycles in the middle of a frame
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h5678, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 23);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 10);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 30);

      // Reset in the middle of a frame while a value is pending
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h9ABC, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 3);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 20);

      // Randomized soak: occasional resets, display toggles and offers
      for (int k = 0; k < 600; k++) begin
         rR      = ($urandom_range(0, 149) == 0);
         rE      = ($urandom_range(0, 9) != 0);
         rV      = ($urandom_range(0, 3) == 0);
         mask    = 16'hFFFF >> (4 * $urandom_range(0, 4));
         randVal = 16'($urandom()) & mask;
         applyStimulus(rR, rE, rV, randVal, 1);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
